// File: rtl/id_ex_operand_stage.sv
// ID/EX operand pipeline stage.
// Registers the decoded operands, immediate and control fields. ALU operands
// are resolved combinationally through EX/MEM and MEM/WB forwarding.
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   stall_i, flush_i        hazard-unit hold / bubble insertion
//   id_*                    decoded instruction fields from the decode stage
//   exm_*, mwb_*            EX/MEM and MEM/WB write-back forwarding sources
//   data1_o, data2_o        ALU operands (data2 is imm when alu_src is set)
//   alu_ctrl_o, rd_addr_o   ALU operation and destination passed downstream
//   reg_write_o, valid_o    write enable (valid-gated) and stage valid
//   rs2_fwd_o               forwarded rs2 regardless of alu_src (store data)
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_write_i,
  input  logic              exm_reg_write_i,
  input  logic [REG_AW-1:0] exm_rd_addr_i,
  input  logic [XLEN-1:0]   exm_data_i,
  input  logic              mwb_reg_write_i,
  input  logic [REG_AW-1:0] mwb_rd_addr_i,
  input  logic [XLEN-1:0]   mwb_data_i,
  output logic [XLEN-1:0]   data1_o,
  output logic [XLEN-1:0]   data2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic [XLEN-1:0]   rs2_fwd_o,
  output logic              valid_o
);

  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              valid_q;

  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd1 = rs1_data_q;
    if (exm_reg_write_i && (exm_rd_addr_i == rs1_q) && (rs1_q != '0)) begin
      fwd1 = exm_data_i;
    end else if (mwb_reg_write_i && (mwb_rd_addr_i == rs1_q) && (rs1_q != '0)) begin
      fwd1 = mwb_data_i;
    end
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (exm_reg_write_i && (exm_rd_addr_i == rs2_q) && (rs2_q != '0)) begin
      fwd2 = exm_data_i;
    end else if (mwb_reg_write_i && (mwb_rd_addr_i == rs2_q) && (rs2_q != '0)) begin
      fwd2 = mwb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else if (stall_i) begin
      // Refresh held operands so a write-back retiring mid-stall is kept.
      rs1_data_q <= fwd1;
      rs2_data_q <= fwd2;
    end else begin
      rs1_data_q  <= id_rs1_data_i;
      rs2_data_q  <= id_rs2_data_i;
      imm_q       <= id_imm_i;
      rs1_q       <= id_rs1_addr_i;
      rs2_q       <= id_rs2_addr_i;
      rd_q        <= id_rd_addr_i;
      alu_ctrl_q  <= id_alu_ctrl_i;
      alu_src_q   <= id_alu_src_i;
      reg_write_q <= id_reg_write_i & id_valid_i;
      valid_q     <= id_valid_i;
    end
  end

  assign data1_o     = fwd1;
  assign data2_o     = alu_src_q ? imm_q : fwd2;
  assign rs2_fwd_o   = fwd2;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rd_addr_o   = rd_q;
  assign reg_write_o = reg_write_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_id_ex_operand_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 3;

  logic              clk;
  logic              rst, stall, flush;
  logic              id_valid;
  logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [CTRL_W-1:0] id_alu_ctrl;
  logic              id_alu_src, id_reg_write;
  logic              exm_rw, mwb_rw;
  logic [REG_AW-1:0] exm_rd, mwb_rd;
  logic [XLEN-1:0]   exm_data, mwb_data;
  logic [XLEN-1:0]   data1, data2, rs2_fwd;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [REG_AW-1:0] rd_addr;
  logic              reg_write, valid;

  id_ex_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .flush_i        (flush),
    .id_valid_i     (id_valid),
    .id_rs1_data_i  (id_rs1_data),
    .id_rs2_data_i  (id_rs2_data),
    .id_imm_i       (id_imm),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rd_addr_i   (id_rd_addr),
    .id_alu_ctrl_i  (id_alu_ctrl),
    .id_alu_src_i   (id_alu_src),
    .id_reg_write_i (id_reg_write),
    .exm_reg_write_i(exm_rw),
    .exm_rd_addr_i  (exm_rd),
    .exm_data_i     (exm_data),
    .mwb_reg_write_i(mwb_rw),
    .mwb_rd_addr_i  (mwb_rd),
    .mwb_data_i     (mwb_data),
    .data1_o        (data1),
    .data2_o        (data2),
    .alu_ctrl_o     (alu_ctrl),
    .rd_addr_o      (rd_addr),
    .reg_write_o    (reg_write),
    .rs2_fwd_o      (rs2_fwd),
    .valid_o        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction currently held in the stage.
  typedef struct {
    logic              valid;
    logic              rw;
    logic              src;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   v1, v2, imm;
  } instr_t;

  instr_t m;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value an operand register resolves to given the current write-back traffic.
  function automatic logic [XLEN-1:0] resolve(input logic [REG_AW-1:0] r,
                                              input logic [XLEN-1:0] held);
    if (r == 0) return held;
    if (exm_rw && exm_rd == r) return exm_data;
    if (mwb_rw && mwb_rd == r) return mwb_data;
    return held;
  endfunction

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rw = 0; b.src = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0;
    b.ctrl = 0; b.v1 = 0; b.v2 = 0; b.imm = 0;
    return b;
  endfunction

  task automatic model_edge();
    if (rst || flush) begin
      m = bubble();
    end else if (stall) begin
      m.v1 = resolve(m.rs1, m.v1);
      m.v2 = resolve(m.rs2, m.v2);
    end else begin
      m.valid = id_valid;      m.rw  = id_reg_write && id_valid;
      m.src   = id_alu_src;    m.rs1 = id_rs1_addr;  m.rs2 = id_rs2_addr;
      m.rd    = id_rd_addr;    m.ctrl = id_alu_ctrl;
      m.v1    = id_rs1_data;   m.v2  = id_rs2_data;  m.imm = id_imm;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [XLEN-1:0] f2;
    f2 = resolve(m.rs2, m.v2);
    check({tag, ".data1"}, data1, resolve(m.rs1, m.v1));
    check({tag, ".data2"}, data2, m.src ? m.imm : f2);
    check({tag, ".rs2fwd"}, rs2_fwd, f2);
    check({tag, ".ctrl"}, XLEN'(alu_ctrl), XLEN'(m.ctrl));
    check({tag, ".rd"}, XLEN'(rd_addr), XLEN'(m.rd));
    check({tag, ".rw"}, XLEN'(reg_write), XLEN'(m.rw));
    check({tag, ".valid"}, XLEN'(valid), XLEN'(m.valid));
  endtask

  task automatic fwd_idle();
    exm_rw = 0; exm_rd = 0; exm_data = 0;
    mwb_rw = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  task automatic drive_id(input logic v, input logic [REG_AW-1:0] a1, a2, d,
                          input logic [CTRL_W-1:0] c, input logic src, rw,
                          input logic [XLEN-1:0] x1, x2, imm);
    id_valid = v; id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = d;
    id_alu_ctrl = c; id_alu_src = src; id_reg_write = rw;
    id_rs1_data = x1; id_rs2_data = x2; id_imm = imm;
  endtask

  task automatic drive_id_random();
    drive_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom);
  endtask

  initial begin
    m = bubble();
    rst = 1; stall = 0; flush = 0;
    fwd_idle();
    drive_id_random();
    #1;
    // Reset with random decode inputs.
    tick();
    drive_id_random();
    tick();
    check("rst.valid", XLEN'(valid), 0);
    check("rst.rw", XLEN'(reg_write), 0);
    check("rst.ctrl", XLEN'(alu_ctrl), 0);
    check("rst.data1", data1, 0);
    check("rst.data2", data2, 0);
    check("rst.rs2fwd", rs2_fwd, 0);
    check_model("rst");

    // ADD x3, x1, x2.
    rst = 0;
    drive_id(1, 1, 2, 3, 3'b011, 0, 1, 5, 7, 32'h1234);
    tick();
    check("add.data1", data1, 5);
    check("add.data2", data2, 7);
    check("add.ctrl", XLEN'(alu_ctrl), 3'b011);
    check("add.rd", XLEN'(rd_addr), 3);
    check("add.rw", XLEN'(reg_write), 1);
    check_model("add");

    // ADDI x4, x1, -3.
    drive_id(1, 1, 2, 4, 3'b110, 1, 1, 10, 32'h77, 32'hFFFF_FFFD);
    tick();
    check("addi.data1", data1, 10);
    check("addi.data2", data2, 32'hFFFF_FFFD);
    check("addi.rs2fwd", rs2_fwd, 32'h77);
    check("addi.ctrl", XLEN'(alu_ctrl), 3'b110);

    // Forwarding priority on rs1 = x6.
    drive_id(1, 6, 0, 7, 3'b000, 0, 1, 32'h99, 0, 0);
    tick();
    exm_rw = 1; exm_rd = 6; exm_data = 32'h11;
    mwb_rw = 1; mwb_rd = 6; mwb_data = 32'h22;
    #1 check("fwd.exm", data1, 32'h11);
    check_model("fwd.exm");
    exm_rw = 0;
    #1 check("fwd.mwb", data1, 32'h22);
    check_model("fwd.mwb");
    fwd_idle();
    drive_id(1, 0, 0, 7, 3'b001, 0, 1, 32'h33, 0, 0);
    tick();
    exm_rw = 1; exm_rd = 0; exm_data = 32'hFF;
    mwb_rw = 1; mwb_rd = 0; mwb_data = 32'hFF;
    #1 check("fwd.x0", data1, 32'h33);
    check_model("fwd.x0");
    fwd_idle();

    // Stall retention: SUB with stale rs2 = x9.
    drive_id(1, 1, 9, 5, 3'b100, 0, 1, 3, 0, 0);
    tick();
    stall = 1;
    drive_id_random();
    mwb_rw = 1; mwb_rd = 9; mwb_data = 32'h55;
    #1 check("stall.c1", data2, 32'h55);
    tick();
    mwb_rw = 0;
    for (int i = 0; i < 2; i++) begin
      drive_id_random();
      #1 check("stall.hold", data2, 32'h55);
      check("stall.ctrl", XLEN'(alu_ctrl), 3'b100);
      tick();
    end
    stall = 0;
    #1 check("stall.release", data2, 32'h55);
    check_model("stall.release");

    // Flush and stall together with a valid MUL in decode.
    flush = 1; stall = 1;
    drive_id(1, 2, 3, 8, 3'b101, 0, 1, 32'hA, 32'hB, 0);
    tick();
    check("flush.valid", XLEN'(valid), 0);
    check("flush.rw", XLEN'(reg_write), 0);
    check("flush.ctrl", XLEN'(alu_ctrl), 0);
    flush = 0; stall = 0;
    drive_id(1, 2, 3, 8, 3'b101, 0, 1, 32'hA, 32'hB, 0);
    tick();
    check("post_flush.ctrl", XLEN'(alu_ctrl), 3'b101);
    check("post_flush.valid", XLEN'(valid), 1);
    check_model("post_flush");

    // Invalid slot claiming a register write.
    drive_id(0, 1, 2, 9, 3'b011, 0, 1, 1, 2, 0);
    tick();
    check("inv.rw", XLEN'(reg_write), 0);
    check("inv.valid", XLEN'(valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      drive_id_random();
      exm_rw = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
      mwb_rw = 1'($urandom); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom;
      #1 check_model("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Pipeline register between instruction decode and the ALU. It captures decoded operands, the immediate and control fields on each clock.
- It drives the ALU operand inputs (data1, data2, ALUCtrl) through an EX/MEM and MEM/WB forwarding network.
- It supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- XLEN, 32, datapath width; matches ALU operand width.
- REG_AW, 5, register address width.
- CTRL_W, 3, ALU control width; encodings are AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, ADDI=110, SRAI=111.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- stall_i  input  1  hold stage contents (hazard unit).
- flush_i  input  1  replace captured instruction with bubble.
- id_valid_i  input  1  decode slot holds a real instruction.
- id_rs1_data_i  input  XLEN  register file read port 1.
- id_rs2_data_i  input  XLEN  register file read port 2.
- id_imm_i  input  XLEN  sign-extended immediate.
- id_rs1_addr_i  input  REG_AW  source register 1 index.
- id_rs2_addr_i  input  REG_AW  source register 2 index.
- id_rd_addr_i  input  REG_AW  destination index.
- id_alu_ctrl_i  input  CTRL_W  ALU operation.
- id_alu_src_i  input  1  1 selects immediate as operand 2.
- id_reg_write_i  input  1  instruction writes rd.
- exm_reg_write_i  input  1  EX/MEM stage writes its rd.
- exm_rd_addr_i  input  REG_AW  EX/MEM destination.
- exm_data_i  input  XLEN  EX/MEM result.
- mwb_reg_write_i  input  1  MEM/WB stage writes its rd.
- mwb_rd_addr_i  input  REG_AW  MEM/WB destination.
- mwb_data_i  input  XLEN  MEM/WB write-back value.
- data1_o  output  XLEN  ALU operand 1 (forwarded rs1).
- data2_o  output  XLEN  ALU operand 2 (imm or forwarded rs2).
- alu_ctrl_o  output  CTRL_W  ALU operation.
- rd_addr_o  output  REG_AW  destination passed downstream.
- reg_write_o  output  1  registered reg_write gated by valid.
- rs2_fwd_o  output  XLEN  forwarded rs2, regardless of alu_src (store data).
- valid_o  output  1  stage holds a real instruction.

Behaviour:
- Reset (rst_i=1 at a rising edge) loads a bubble. After reset: valid_o=0, reg_write_o=0, alu_ctrl_o=000, rd_addr_o=0, data1_o=0, data2_o=0, rs2_fwd_o=0. Reset has priority over flush and stall and may interrupt a stall.
- Bubble definition: all registered fields are zero, including the address fields and alu_src.
- Priority at each edge is rst_i > flush_i > stall_i > normal capture.
- Normal capture (no stall, no flush): all id_* fields are registered with 1-cycle latency. reg_write is registered as id_reg_write_i & id_valid_i.
- Flush loads a bubble. When flush_i and stall_i are asserted together, flush wins.
- Stall holds addresses, imm, ctrl, alu_src, reg_write and valid.
  - The registered rs1/rs2 values are overwritten with the current forwarded values (fwd1/fwd2 below).
  - This ensures a MEM/WB write that retires during a multi-cycle stall is not lost.
  - A stall with no matching forwarder leaves the values unchanged.
- Forwarding is combinational from the registered state.
  - fwd1: use exm_data_i if exm_reg_write_i and exm_rd_addr_i==rs1_q and rs1_q!=0.
  - Otherwise use mwb_data_i if mwb_reg_write_i and mwb_rd_addr_i==rs1_q and rs1_q!=0.
  - Otherwise use rs1_data_q.
  - fwd2 is identical using rs2_q and rs2_data_q.
  - EX/MEM has priority over MEM/WB.
  - Register x0 is never forwarded, even if an upstream stage claims a write to x0.
- Outputs:
  - data1_o = fwd1.
  - data2_o = alu_src_q ? imm_q : fwd2.
  - rs2_fwd_o = fwd2.
- Operands are passed unmodified; shift-amount masking (data2[4:0] for SRAI) is the ALU's responsibility.
- Outputs are driven by a bubble's zeroed fields even when valid_o=0. Downstream stages qualify results with valid_o/reg_write_o.
- There is no combinational path from any id_* input to any output. The only combinational paths are from exm_*/mwb_* inputs to data1_o, data2_o and rs2_fwd_o.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random id_* inputs -> valid_o=0, reg_write_o=0, alu_ctrl_o=000, data1_o=data2_o=0. Release reset, present ADD x3,x1,x2 with rs1=5, rs2=7 -> next cycle data1_o=5, data2_o=7, alu_ctrl_o=011, rd_addr_o=3, reg_write_o=1.
- Immediate select: ADDI x4,x1,-3 with rs1=10, imm=32'hFFFFFFFD, alu_src=1 -> data2_o=32'hFFFFFFFD, rs2_fwd_o=rs2 register value, alu_ctrl_o=110.
- Forward priority: captured rs1=x6, with EX/MEM writing x6=0x11 and MEM/WB writing x6=0x22 -> data1_o=0x11. Drop the EX/MEM write -> data1_o=0x22. Set rs1=x0 with both writing x0=0xFF -> data1_o=registered rs1 data.
- Stall retention: SUB captured with rs2=x9 (stale 0). Assert stall_i for 3 cycles; in cycle 1 MEM/WB writes x9=0x55, then MEM/WB goes idle -> data2_o stays 0x55 through the remaining stall cycles and the release cycle; alu_ctrl_o stays 100.
- Flush vs stall: assert flush_i and stall_i together with a valid MUL in decode -> next cycle valid_o=0, reg_write_o=0, alu_ctrl_o=000. Deassert both -> the following instruction is captured normally.
- Invalid capture: id_valid_i=0 with id_reg_write_i=1 -> reg_write_o=0, valid_o=0 after one cycle.
